// File: rtl/psram_write_queue.sv
// psram_write_queue: posted-write FIFO and timed read path in front of the PSRAM controller.
// Define PSRAM_WQ_FORWARD_EN to forward queued write data to hazarding reads instead of stalling them.
//
// state  | meaning
// R_IDLE | ready for a host read
// R_REQ  | read presented to the controller (or held off by a hazard / presented write)
// R_WAIT | counting down the controller read latency
// R_DONE | host_rd_valid pulse
module psram_write_queue #(
  parameter int ADDRESS_BITS = 23,
  parameter int DATA_BITS    = 16,
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    host_wr_en,
  input  logic [ADDRESS_BITS-1:0] host_wr_address,
  input  logic [DATA_BITS-1:0]    host_wr_data,
  output logic                    host_wr_ready,
  input  logic                    host_rd_en,
  input  logic [ADDRESS_BITS-1:0] host_rd_address,
  output logic                    host_rd_ready,
  output logic [DATA_BITS-1:0]    host_rd_data,
  output logic                    host_rd_valid,
  output logic                    mem_rd_en,
  output logic [ADDRESS_BITS-1:0] mem_rd_address,
  input  logic                    mem_rd_ack,
  input  logic [DATA_BITS-1:0]    mem_rd_data,
  output logic                    mem_wr_en,
  output logic [ADDRESS_BITS-1:0] mem_wr_address,
  output logic [DATA_BITS-1:0]    mem_wr_data,
  input  logic                    mem_wr_ack
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int LAT_BITS = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);
  localparam logic [LAT_BITS-1:0] LAT_LOAD   = LAT_BITS'(READ_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_DONE} rd_state_t;

  logic [ADDRESS_BITS-1:0] fifo_addr [DEPTH];
  logic [DATA_BITS-1:0]    fifo_data [DEPTH];
  logic [PTR_BITS-1:0]     wr_ptr;
  logic [PTR_BITS-1:0]     rd_ptr;
  logic [CNT_BITS-1:0]     count;
  logic                    push;
  logic                    pop;
  logic                    wr_hold;
  logic                    rd_blocked;
  logic                    match_any;
  rd_state_t               rd_state;
  logic [ADDRESS_BITS-1:0] rd_addr;
  logic [LAT_BITS-1:0]     lat_cnt;
`ifdef PSRAM_WQ_FORWARD_EN
  logic [DATA_BITS-1:0]    fwd_data;
`else
  logic                    haz_wait;
`endif

  assign host_wr_ready  = (count != FULL_COUNT);
  assign push           = host_wr_en && host_wr_ready;
  assign pop            = mem_wr_en && mem_wr_ack;
  assign mem_rd_address = rd_addr;
  assign mem_wr_address = fifo_addr[rd_ptr];
  assign mem_wr_data    = fifo_data[rd_ptr];

  // A write presented last cycle without an ack stays on the bus; reads win otherwise.
  assign mem_rd_en = (rd_state == R_REQ) && !rd_blocked && !wr_hold;
  assign mem_wr_en = (count != '0) && !mem_rd_en;

`ifdef PSRAM_WQ_FORWARD_EN
  assign rd_blocked = 1'b0;
`else
  assign rd_blocked = haz_wait && (count != '0);
`endif

  // Scan oldest to newest so the last hit is the newest matching entry.
  always_comb begin
    match_any = 1'b0;
`ifdef PSRAM_WQ_FORWARD_EN
    fwd_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_BITS'(k) < count) &&
          (fifo_addr[rd_ptr + PTR_BITS'(k)] == host_rd_address)) begin
        match_any = 1'b1;
`ifdef PSRAM_WQ_FORWARD_EN
        fwd_data  = fifo_data[rd_ptr + PTR_BITS'(k)];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_hold <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= host_wr_address;
        fifo_data[wr_ptr] <= host_wr_data;
        wr_ptr            <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_BITS'(1);
      end else if (pop && !push) begin
        count <= count - CNT_BITS'(1);
      end
      wr_hold <= mem_wr_en && !mem_wr_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_state      <= R_IDLE;
      rd_addr       <= '0;
      lat_cnt       <= '0;
      host_rd_ready <= 1'b1;
      host_rd_valid <= 1'b0;
      host_rd_data  <= '0;
`ifndef PSRAM_WQ_FORWARD_EN
      haz_wait      <= 1'b0;
`endif
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (host_rd_en) begin
            rd_addr       <= host_rd_address;
            host_rd_ready <= 1'b0;
`ifdef PSRAM_WQ_FORWARD_EN
            if (match_any) begin
              host_rd_data  <= fwd_data;
              host_rd_valid <= 1'b1;
              rd_state      <= R_DONE;
            end else begin
              rd_state <= R_REQ;
            end
`else
            haz_wait <= match_any;
            rd_state <= R_REQ;
`endif
          end
        end
        R_REQ: begin
          if (mem_rd_en && mem_rd_ack) begin
            lat_cnt  <= LAT_LOAD;
            rd_state <= R_WAIT;
`ifndef PSRAM_WQ_FORWARD_EN
            haz_wait <= 1'b0;
`endif
          end
        end
        R_WAIT: begin
          if (lat_cnt == '0) begin
            host_rd_data  <= mem_rd_data;
            host_rd_valid <= 1'b1;
            rd_state      <= R_DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_BITS'(1);
          end
        end
        R_DONE: begin
          host_rd_valid <= 1'b0;
          host_rd_ready <= 1'b1;
          rd_state      <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/psram_write_queue.md
# psram_write_queue

Request front-end that sits directly upstream of the PSRAM controller and feeds its `rd_en`/`wr_en` request ports. Posts host writes into a small FIFO so the host never waits on the ~3-cycle RAM access. Arbitrates reads ahead of queued writes. Because the controller gives no data-valid strobe, the block times each read and returns data with an explicit `host_rd_valid` pulse. Read-after-write hazards against queued entries are resolved in this block.

## Interface
- `ADDRESS_BITS`, 23: word address width, both banks included.
- `DATA_BITS`, 16: data word width.
- `DEPTH`, 4: write FIFO entries; power of two, ≥2.
- `READ_LATENCY`, 4: cycles from the `mem_rd_ack` cycle T to `mem_rd_data` being valid; data is sampled at the edge ending cycle T+READ_LATENCY.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: reset is synchronous and active-low.
- `host_wr_en` in 1: write request; accepted when `host_wr_ready` is high.
- `host_wr_address` in ADDRESS_BITS: write address.
- `host_wr_data` in DATA_BITS: write data.
- `host_wr_ready` out 1: FIFO not full.
- `host_rd_en` in 1: read request; accepted when `host_rd_ready` is high.
- `host_rd_address` in ADDRESS_BITS: read address.
- `host_rd_ready` out 1: no read outstanding.
- `host_rd_data` out DATA_BITS: read result; holds its value between reads.
- `host_rd_valid` out 1: one-cycle pulse marking `host_rd_data` valid.
- `mem_rd_en`, `mem_rd_address`: out; read request to the controller.
- `mem_rd_ack` in 1: controller accepted the read (combinational, same cycle).
- `mem_rd_data` in DATA_BITS: controller read data.
- `mem_wr_en`, `mem_wr_address`, `mem_wr_data`: out; write request to the controller.
- `mem_wr_ack` in 1: controller accepted the write.

## Operation
Write FIFO:
- A push occurs on `host_wr_en && host_wr_ready`.
- A pop occurs on `mem_wr_ack`.
- Push and pop in the same cycle are both honoured, and the count is unchanged.
- `host_wr_ready = (count != DEPTH)`. No push is accepted when full, even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. `count` is $clog2(DEPTH+1) bits wide.

Read FSM:
- States: R_IDLE, R_REQ, R_WAIT, R_DONE.
- R_IDLE: `host_rd_ready` is 1. On an accept, the address is latched. If there is a hazard hit (see Configuration), go to R_DONE with forwarded data. Otherwise go to R_REQ.
- R_REQ: drive `mem_rd_en` with the latched address and hold it until `mem_rd_ack`. In the ack cycle, load the latency counter with READ_LATENCY-1 and go to R_WAIT.
- R_WAIT: decrement the counter. At 0, register `mem_rd_data` into `host_rd_data` and go to R_DONE.
- R_DONE: `host_rd_valid` is 1 for this cycle; return to R_IDLE.

Memory-side arbitration:
- The block never drives `mem_rd_en` and `mem_wr_en` together.
- `mem_rd_en` is driven in R_REQ. If the read is blocked by a hazard, it is not driven until the hazard clears.
- Otherwise `mem_wr_en = (count != 0)`, presenting the FIFO head.
- A write that is already presented is not withdrawn before its ack. A newly accepted read waits until that ack.

Reset values:
- All outputs are 0, except `host_wr_ready` and `host_rd_ready`, which are 1.
- The FIFO is emptied and the read FSM goes to R_IDLE.
- Reset mid-read discards the outstanding read and produces no `host_rd_valid`. Reset mid-write drops queued entries, so the caller must drain the FIFO first.

## Timing
- `host_wr_ready` and `host_rd_ready` are registered-state decodes with no combinational path from `host_*_en`.
- `mem_*_en` and the addresses come from registers and the FIFO head, not combinationally from host inputs.
- Read latency (no hazard, memory idle): accept cycle A, `mem_rd_en` from A+1, ack at A+1, data sampled at A+1+READ_LATENCY, `host_rd_valid` at A+2+READ_LATENCY. This is A+6 at defaults.
- Forwarded read: `host_rd_valid` at A+1.
- Write posting: the first write to an empty FIFO appears on `mem_wr_en` the following cycle.

## Configuration
- `PSRAM_WQ_FORWARD_EN` defined:
  - On read accept, the latched address is compared against all valid FIFO entries.
  - The newest matching entry's data goes to R_DONE with no memory access.
- `PSRAM_WQ_FORWARD_EN` undefined:
  - A read whose address matches any valid entry stays in R_REQ without asserting `mem_rd_en` until the FIFO is empty.
  - It then reads the memory normally.
- Non-matching reads behave identically in both builds.

## Test plan
- Reset with host inputs idle → all `mem_*_en` low, `host_wr_ready`=1, `host_rd_ready`=1, `host_rd_valid`=0.
- Five back-to-back writes, no `mem_wr_ack` → four accepted, `host_wr_ready`=0 on the fifth. Acks then appear on `mem_wr_*` in order with the correct address/data.
- Read 0x000123 on an idle FIFO, controller model acks immediately and drives 0xBEEF at READ_LATENCY → `host_rd_valid` at accept+6 with 0xBEEF, pulse one cycle.
- Write 0x10←0x1111, write 0x10←0x2222, then read 0x10:
  - With the macro: `host_rd_valid` one cycle later with 0x2222, and no `mem_rd_en`.
  - Without the macro: `mem_rd_en` only after both write acks, returning the model's memory content 0x2222.
- Read issued while a write is presented but not yet acked → `mem_wr_en` is held until the ack and `mem_rd_en` is never high simultaneously. The read then completes.
- `reset_n` low during R_WAIT → no `host_rd_valid`, FIFO empty, `host_rd_ready`=1 after release.
